fir_ntap_mac: RTL

- Parametrised successor to the 4-tap 8-bit FIR: N taps, signed data, programmable coefficients, one time-multiplexed multiply-accumulate unit.
- Takes one input sample per handshake, computes y = sum(h[i]*x[n-i]) over TAPS cycles, then rounds, scales and saturates the result onto the output.
- Sits in the sample datapath between the source and the downstream consumer; coefficients are loaded over a simple write port.

---
 rtl/fir_pkg.sv | 50 +++++
 rtl/fir_ntap_mac_round_sat.sv | 19 +
 rtl/fir_ntap_mac.sv | 111 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the N-tap FIR MAC:
// width derivation, FSM states, round/shift/saturate.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator wide enough that TAPS full-scale
  // products cannot overflow.
  function automatic int acc_w(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + clog2(taps);
  endfunction

  // Round half up, arithmetic shift, clamp to a
  // signed ow-bit range. Carried at 64 bits.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] a,
    input int                 shift,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    r = a;
    if (shift > 0) r = a + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (ow - 1));
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
  endfunction

endpackage

// File: rtl/fir_ntap_mac_round_sat.sv
// Combinational round + shift + saturate, AW -> OW.
// acc_i: signed accumulator, y_o: signed clamped result.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int AW    = 18,
  parameter int OW    = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [OW-1:0] y_o
);

  logic signed [63:0] r;

  assign r   = round_sat(64'(acc_i), SHIFT, OW);
  assign y_o = OW'(r);

endmodule

// File: rtl/fir_ntap_mac.sv
// N-tap FIR, one shared MAC, programmable coefficients.
// Ports: sample handshake, coef write port, flush, y/out_valid.
module fir_ntap_mac
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int OW    = 8,
  parameter int TAPS  = 4,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DW-1:0]     in_data,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]     coef_data,
  output logic                     out_valid,
  output logic signed [OW-1:0]     y
);

  localparam int AB = clog2(TAPS);
  localparam int AW = acc_w(DW, CW, TAPS);
  localparam int PW = DW + CW;
  localparam logic [AB-1:0] KL = AB'(TAPS - 1);

  state_e                state_q;
  logic signed [DW-1:0]  x_q [TAPS];
  logic signed [CW-1:0]  h_q [TAPS];
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;
  logic [AB-1:0]         k_q;
  logic signed [OW-1:0]  y_q;
  logic signed [OW-1:0]  y_d;
  logic                  ov_q;
  logic signed [PW-1:0]  prod;
  logic                  addr_ok;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = ov_q;
  assign y         = y_q;

  assign addr_ok = (int'(coef_addr) < TAPS);
  assign prod    = x_q[k_q] * h_q[k_q];
  assign acc_d   = acc_q + AW'(prod);

  fir_round_sat #(
    .AW    (AW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_rs (
    .acc_i (acc_q),
    .y_o   (y_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      y_q     <= '0;
      ov_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= CW'(1);
      end
    end else if (flush) begin
      // Flush beats any sample or coef write.
      state_q <= ST_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      ov_q    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      ov_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (coef_we && addr_ok) begin
            h_q[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
              x_q[i] <= x_q[i-1];
            end
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + AB'(1);
          if (k_q == KL) state_q <= ST_OUT;
        end
        ST_OUT: begin
          y_q     <= y_d;
          ov_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
